prog_sequencer: RTL and testbench
=================================

// Module: prog_sequencer
// PURPOSE
//  Upstream controller for the instruction fetch stage. Runs the Start/Ack program handshake.
//  Holds the PC while Start is high. On Start release, launches the next program by forcing an
//  absolute load of that program's base address. Counts execution cycles until the decoder
//  reports Halt, then acknowledges. Its outputs drive the fetch stage's Start, BranchAbs and Target inputs.
// PARAMETERS
//  PC_W        10     program counter / target width
//  CNT_W       16     cycle counter width
//  PROG0_BASE  10'd0    base address of program 0
//  PROG1_BASE  10'd256  base address of program 1
//  PROG2_BASE  10'd512  base address of program 2
//  MAX_CYCLES  16'hFFF0 watchdog limit (used only with PROG_SEQ_WATCHDOG_EN)
// PORTS
//  Clk         in   1      clock; all state changes on posedge only
//  Reset       in   1      synchronous, active-high reset
//  Start       in   1      bench request: high = hold/arm, falling edge = launch
//  Halt        in   1      decoder saw halt instruction (valid only in RUN)
//  FetchHold   out  1      to fetch Start: 1 = freeze PC
//  FetchLoad   out  1      to fetch BranchAbs: 1-cycle pulse, load LoadTarget
//  LoadTarget  out  PC_W   base address of the current program (from ProgIdx)
//  ProgIdx     out  2      current program index 0..2
//  Running     out  1      1 while in RUN
//  Ack         out  1      1 while in DONE
//  CycleCount  out  CNT_W  RUN cycles of the last/current program
//  Timeout     out  1      watchdog fired (tied 0 without macro)
// BEHAVIOUR
//  States: IDLE, ARMED, LAUNCH, RUN, DONE (registered; Moore outputs).
//  Reset (any state, mid-run included), next cycle:
//   - state=IDLE, ProgIdx=0, CycleCount=0, Timeout=0
//   - FetchHold=1, FetchLoad=0, Ack=0, Running=0
//  Transitions:
//   - IDLE: Start=1 -> ARMED; else stay.
//   - ARMED: FetchHold=1. Start=0 -> LAUNCH.
//   - LAUNCH: exactly 1 cycle. FetchLoad=1, FetchHold=0, CycleCount cleared to 0. -> RUN.
//   - RUN: FetchHold=0, Running=1, CycleCount+1 every cycle. Counting saturates at all-ones, no wrap.
//   - RUN + Halt=1: -> DONE. The halt cycle is counted. ProgIdx increments 0->1->2->0 on entry to DONE.
//   - DONE: Ack=1, FetchHold=1, CycleCount held. Start=1 -> ARMED (Ack drops next cycle).
//  LoadTarget = PROGn_BASE for ProgIdx=n (combinational mux on registered ProgIdx).
//  Ignored inputs:
//   - Halt outside RUN; Halt during LAUNCH.
//   - Start in LAUNCH/RUN; Start=1 held in ARMED just stays ARMED.
//  RUN with Halt=1 and Start=1 together: Halt wins -> DONE.
//  Latency: Start fall at edge k -> FetchLoad high cycle k+1 -> PC = base after edge k+2.
// CONFIGURATION
//  `PROG_SEQ_WATCHDOG_EN defined:
//   - In RUN, CycleCount==MAX_CYCLES-1 without Halt -> DONE with Timeout=1.
//   - Timeout clears on entry to ARMED or on Reset. ProgIdx still advances.
//  Not defined: no watchdog logic; Timeout tied 0; RUN lasts until Halt.
// STRUCTURE
//  prog_seq_pkg: state enum seq_state_t, NUM_PROGS=3, PROG_IDX_W=2.
//  Sub-module prog_cycle_counter: saturating counter with clear/enable; also owns the watchdog compare.
//  FSM and base-address mux stay in prog_sequencer.
// TESTING
//  1. Reset 2 cycles -> FetchHold=1, Ack=0, ProgIdx=0, CycleCount=0, LoadTarget=0.
//  2. Start 1 for 3 cycles, then 0; Halt after 5 RUN cycles:
//     - FetchLoad one pulse, LoadTarget=0
//     - Ack=1, CycleCount=5, ProgIdx=1
//  3. Three back-to-back programs -> LoadTarget 0, 256, 512; then ProgIdx wraps to 0.
//  4. Halt and Start both high in the same RUN cycle -> DONE, Ack=1; Start then re-arms.
//  5. Reset asserted mid-RUN with CycleCount=7 -> IDLE, CycleCount=0, ProgIdx=0, FetchHold=1.
//  6. With macro, MAX_CYCLES=8, no Halt -> Timeout=1, Ack=1 and CycleCount=8 after 8 RUN cycles.
//     Without macro: still RUN.

Source files
------------

// File: rtl/prog_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// prog_seq_pkg
//   Shared types and constants for the program sequencer slice.
//   - seq_state_t  : sequencer FSM states (IDLE, ARMED, LAUNCH, RUN, DONE)
//   - NUM_PROGS    : number of programs cycled through (3)
//   - PROG_IDX_W   : width of the program index (2)
//   - next_prog_idx: program index advance with wrap 0->1->2->0
// ---------------------------------------------------------------------------
package prog_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_LAUNCH = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } seq_state_t;

    localparam int unsigned NUM_PROGS  = 3;
    localparam int unsigned PROG_IDX_W = 2;

    function automatic logic [PROG_IDX_W-1:0] next_prog_idx(
        input logic [PROG_IDX_W-1:0] idx
    );
        logic [PROG_IDX_W-1:0] nxt;
        if (idx >= PROG_IDX_W'(NUM_PROGS - 1))
            nxt = '0;
        else
            nxt = idx + 1'b1;
        return nxt;
    endfunction

endpackage

// File: rtl/prog_sequencer_cycle_counter.sv
// ---------------------------------------------------------------------------
// prog_cycle_counter
//   Saturating execution-cycle counter with synchronous clear and enable.
//   Also owns the watchdog limit compare.
//   Optional feature macro: PROG_SEQ_WATCHDOG_EN (enables the limit compare;
//   otherwise at_limit is tied 0).
// Ports
//   clk      in   clock
//   reset    in   synchronous active-high reset (count -> 0)
//   clear    in   synchronous clear (count -> 0)
//   enable   in   count up by one, holding at all-ones
//   count    out  CNT_W current count
//   at_limit out  count == MAX_CYCLES-1 (watchdog build only)
// ---------------------------------------------------------------------------
module prog_cycle_counter #(
    parameter int unsigned      CNT_W      = 16,
    parameter logic [CNT_W-1:0] MAX_CYCLES = CNT_W'('hFFF0)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable && (count != '1))
            count <= count + 1'b1;
    end

`ifdef PROG_SEQ_WATCHDOG_EN
    // Compare against MAX_CYCLES-1 so the cycle that reaches MAX_CYCLES is the
    // one that leaves RUN.
    assign at_limit = (count == (MAX_CYCLES - 1'b1));
`else
    logic unused_max_cycles;
    assign unused_max_cycles = ^MAX_CYCLES;
    assign at_limit          = 1'b0;
`endif

endmodule

// File: rtl/prog_sequencer.sv
// ---------------------------------------------------------------------------
// prog_sequencer
//   Upstream controller for the instruction fetch stage. Runs the Start/Ack
//   program handshake: holds the PC while armed, forces an absolute load of
//   the next program's base address on Start release, counts RUN cycles until
//   Halt, then acknowledges.
//   Optional feature macro: PROG_SEQ_WATCHDOG_EN (RUN watchdog -> Timeout).
// Ports
//   Clk        in   clock
//   Reset      in   synchronous active-high reset
//   Start      in   high = hold/arm, falling edge = launch
//   Halt       in   decoder saw halt (only honoured in RUN)
//   FetchHold  out  1 = freeze fetch PC
//   FetchLoad  out  1-cycle pulse: fetch loads LoadTarget
//   LoadTarget out  PC_W base address of the current program
//   ProgIdx    out  current program index 0..2
//   Running    out  1 while in RUN
//   Ack        out  1 while in DONE
//   CycleCount out  CNT_W RUN cycles of the last/current program
//   Timeout    out  watchdog fired (0 without the macro)
// ---------------------------------------------------------------------------
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int unsigned      PC_W       = 10,
    parameter int unsigned      CNT_W      = 16,
    parameter logic [PC_W-1:0]  PROG0_BASE = PC_W'(0),
    parameter logic [PC_W-1:0]  PROG1_BASE = PC_W'(256),
    parameter logic [PC_W-1:0]  PROG2_BASE = PC_W'(512),
    parameter logic [CNT_W-1:0] MAX_CYCLES = CNT_W'('hFFF0)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Halt,
    output logic                  FetchHold,
    output logic                  FetchLoad,
    output logic [PC_W-1:0]       LoadTarget,
    output logic [PROG_IDX_W-1:0] ProgIdx,
    output logic                  Running,
    output logic                  Ack,
    output logic [CNT_W-1:0]      CycleCount,
    output logic                  Timeout
);

    seq_state_t            state;
    seq_state_t            state_next;
    logic [PROG_IDX_W-1:0] prog_idx;
    logic                  at_limit;

    prog_cycle_counter #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_counter (
        .clk      (Clk),
        .reset    (Reset),
        .clear    (state == S_LAUNCH),
        .enable   (state == S_RUN),
        .count    (CycleCount),
        .at_limit (at_limit)
    );

    // Halt takes priority over Start in RUN; Start is ignored in LAUNCH/RUN.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (Start)            state_next = S_ARMED;
            S_ARMED:  if (!Start)           state_next = S_LAUNCH;
            S_LAUNCH:                       state_next = S_RUN;
            S_RUN:    if (Halt || at_limit) state_next = S_DONE;
            S_DONE:   if (Start)            state_next = S_ARMED;
            default:                        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            prog_idx <= '0;
        end else begin
            state <= state_next;
            if ((state == S_RUN) && (state_next == S_DONE))
                prog_idx <= next_prog_idx(prog_idx);
        end
    end

`ifdef PROG_SEQ_WATCHDOG_EN
    logic timeout_q;

    always_ff @(posedge Clk) begin
        if (Reset)
            timeout_q <= 1'b0;
        else if ((state == S_RUN) && !Halt && at_limit)
            timeout_q <= 1'b1;
        else if ((state != S_ARMED) && (state_next == S_ARMED))
            timeout_q <= 1'b0;
    end

    assign Timeout = timeout_q;
`else
    assign Timeout = 1'b0;
`endif

    always_comb begin
        case (prog_idx)
            2'd0:    LoadTarget = PROG0_BASE;
            2'd1:    LoadTarget = PROG1_BASE;
            default: LoadTarget = PROG2_BASE;
        endcase
    end

    assign ProgIdx   = prog_idx;
    assign FetchHold = !((state == S_LAUNCH) || (state == S_RUN));
    assign FetchLoad = (state == S_LAUNCH);
    assign Running   = (state == S_RUN);
    assign Ack       = (state == S_DONE);

endmodule

// File: tb/tb_prog_sequencer.sv
// ---------------------------------------------------------------------------
// tb_prog_sequencer
//   Self-checking bench for prog_sequencer: directed scenarios with literal
//   expectations, then randomized Start/Halt/Reset traffic, all compared
//   every cycle against a behavioural model of the handshake.
//   Honours PROG_SEQ_WATCHDOG_EN (MAX_CYCLES overridden to 8).
// ---------------------------------------------------------------------------
module tb_prog_sequencer;

`ifdef PROG_SEQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif
    localparam int unsigned MAXC = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        halt;
    logic        fetch_hold;
    logic        fetch_load;
    logic [9:0]  load_target;
    logic [1:0]  prog_idx;
    logic        running;
    logic        ack;
    logic [15:0] cycle_count;
    logic        timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int load_pulses = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    prog_sequencer #(
        .PC_W       (10),
        .CNT_W      (16),
        .PROG0_BASE (10'd0),
        .PROG1_BASE (10'd256),
        .PROG2_BASE (10'd512),
        .MAX_CYCLES (16'd8)
    ) dut (
        .Clk        (clk),
        .Reset      (reset),
        .Start      (start),
        .Halt       (halt),
        .FetchHold  (fetch_hold),
        .FetchLoad  (fetch_load),
        .LoadTarget (load_target),
        .ProgIdx    (prog_idx),
        .Running    (running),
        .Ack        (ack),
        .CycleCount (cycle_count),
        .Timeout    (timeout)
    );

    // Behavioural model: which phase of the handshake we are in, how many
    // RUN cycles have elapsed, which program is current.
    localparam int P_IDLE = 0, P_ARMED = 1, P_LAUNCH = 2, P_RUN = 3, P_DONE = 4;
    int          m_phase = P_IDLE;
    int unsigned m_count = 0;
    int unsigned m_idx   = 0;
    bit          m_to    = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= P_IDLE;
            m_count <= 0;
            m_idx   <= 0;
            m_to    <= 1'b0;
        end else begin
            case (m_phase)
                P_IDLE:   if (start) begin m_phase <= P_ARMED; m_to <= 1'b0; end
                P_ARMED:  if (!start) m_phase <= P_LAUNCH;
                P_LAUNCH: begin m_phase <= P_RUN; m_count <= 0; end
                P_RUN: begin
                    m_count <= (m_count < 65535) ? m_count + 1 : m_count;
                    if (halt) begin
                        m_phase <= P_DONE;
                        m_idx   <= (m_idx + 1) % 3;
                    end else if (WD && (m_count == MAXC - 1)) begin
                        m_phase <= P_DONE;
                        m_idx   <= (m_idx + 1) % 3;
                        m_to    <= 1'b1;
                    end
                end
                P_DONE:   if (start) begin m_phase <= P_ARMED; m_to <= 1'b0; end
                default:  m_phase <= P_IDLE;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check("cyc_hold",    32'(fetch_hold),  32'(!(m_phase == P_LAUNCH || m_phase == P_RUN)));
            check("cyc_load",    32'(fetch_load),  32'(m_phase == P_LAUNCH));
            check("cyc_target",  32'(load_target), m_idx * 256);
            check("cyc_idx",     32'(prog_idx),    m_idx);
            check("cyc_running", 32'(running),     32'(m_phase == P_RUN));
            check("cyc_ack",     32'(ack),         32'(m_phase == P_DONE));
            check("cyc_count",   32'(cycle_count), m_count);
            check("cyc_timeout", 32'(timeout),     32'(m_to));
            if (fetch_load === 1'b1)
                load_pulses++;
        end
    end

    task automatic step(input bit s, input bit h);
        start = s;
        halt  = h;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses_before;

        reset = 1'b1;
        start = 1'b0;
        halt  = 1'b0;

        // 1. reset for two cycles
        step(0, 0);
        checking = 1'b1;
        step(0, 0);
        check("t1_hold",   32'(fetch_hold),  32'd1);
        check("t1_ack",    32'(ack),         32'd0);
        check("t1_idx",    32'(prog_idx),    32'd0);
        check("t1_count",  32'(cycle_count), 32'd0);
        check("t1_target", 32'(load_target), 32'd0);
        reset = 1'b0;

        // 2. Start high 3 cycles, release, halt on the 5th RUN cycle
        pulses_before = load_pulses;
        step(1, 0); step(1, 0); step(1, 0);
        check("t2_armed_hold", 32'(fetch_hold), 32'd1);
        step(0, 0);
        check("t2_load",       32'(fetch_load),  32'd1);
        check("t2_load_hold",  32'(fetch_hold),  32'd0);
        check("t2_load_tgt",   32'(load_target), 32'd0);
        step(0, 0);
        check("t2_run",        32'(running),     32'd1);
        check("t2_run_load",   32'(fetch_load),  32'd0);
        repeat (4) step(0, 0);
        step(0, 1);
        check("t2_ack",         32'(ack),         32'd1);
        check("t2_count",       32'(cycle_count), 32'd5);
        check("t2_idx",         32'(prog_idx),    32'd1);
        check("t2_model_count", m_count,          32'd5);
        step(0, 0);
        check("t2_count_held",  32'(cycle_count), 32'd5);
        check("t2_pulses",      32'(load_pulses - pulses_before), 32'd1);

        // 3. three back-to-back programs from reset
        reset = 1'b1;
        step(0, 0);
        reset = 1'b0;
        for (int p = 0; p < 3; p++) begin
            step(1, 0);
            step(0, 0);
            check("t3_target",       32'(load_target), 32'(p * 256));
            check("t3_model_target", m_idx * 256,      32'(p * 256));
            step(0, 0);
            step(0, 0);
            step(0, 1);
            check("t3_ack", 32'(ack), 32'd1);
        end
        check("t3_wrap", 32'(prog_idx), 32'd0);

        // 4. Halt and Start together in RUN -> DONE, then Start re-arms
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        step(1, 1);
        check("t4_ack",     32'(ack),         32'd1);
        check("t4_running", 32'(running),     32'd0);
        check("t4_count",   32'(cycle_count), 32'd2);
        check("t4_idx",     32'(prog_idx),    32'd1);
        step(1, 0);
        check("t4_rearm_ack",  32'(ack),        32'd0);
        check("t4_rearm_hold", 32'(fetch_hold), 32'd1);

        // 5. reset in the middle of RUN with CycleCount=7
        step(0, 0);
        step(0, 0);
        repeat (7) step(0, 0);
        check("t5_pre_count", 32'(cycle_count), 32'd7);
        check("t5_pre_run",   32'(running),     32'd1);
        reset = 1'b1;
        step(0, 0);
        reset = 1'b0;
        check("t5_hold",    32'(fetch_hold),  32'd1);
        check("t5_count",   32'(cycle_count), 32'd0);
        check("t5_idx",     32'(prog_idx),    32'd0);
        check("t5_running", 32'(running),     32'd0);

        // 6. no Halt for 8 RUN cycles
        step(1, 0);
        step(0, 0);
        step(0, 0);
        repeat (8) step(0, 0);
        check("t6_count", 32'(cycle_count), 32'd8);
`ifdef PROG_SEQ_WATCHDOG_EN
        check("t6_timeout", 32'(timeout),  32'd1);
        check("t6_ack",     32'(ack),      32'd1);
        check("t6_idx",     32'(prog_idx), 32'd1);
        step(1, 0);
        check("t6_to_clear", 32'(timeout), 32'd0);
`else
        check("t6_running", 32'(running), 32'd1);
        check("t6_timeout", 32'(timeout), 32'd0);
        check("t6_ack",     32'(ack),     32'd0);
`endif
        step(0, 1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
        end
        reset = 1'b0;
        step(0, 0);
        checking = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
